// File: rtl/rf_pkg.sv
// Shared defaults for the scoreboarded register file.
package rf_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_CNTW = 2;
  localparam int X0       = 0;
endpackage

// File: rtl/scoreboard_regfile_if.sv
// Issue, source read, commit and flush bundle between the pipeline and the register file.
interface scoreboard_regfile_if
  import rf_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                 issue_valid_i;
  logic                 issue_fire_i;
  logic                 issue_wena_i;
  logic [AW-1:0]        issue_waddr_i;
  logic [NRD-1:0]       rena_i;
  logic [NRD*AW-1:0]    raddr_i;
  logic [NRD*XLEN-1:0]  rdata_o;
  logic                 hazard_o;
  logic                 commit_valid_i;
  logic                 commit_wena_i;
  logic [AW-1:0]        commit_waddr_i;
  logic [XLEN-1:0]      commit_wdata_i;
  logic                 flush_i;

  modport master (
    output issue_valid_i, issue_fire_i, issue_wena_i, issue_waddr_i,
    output rena_i, raddr_i,
    output commit_valid_i, commit_wena_i, commit_waddr_i, commit_wdata_i,
    output flush_i,
    input  rdata_o, hazard_o
  );

  modport slave (
    input  issue_valid_i, issue_fire_i, issue_wena_i, issue_waddr_i,
    input  rena_i, raddr_i,
    input  commit_valid_i, commit_wena_i, commit_waddr_i, commit_wdata_i,
    input  flush_i,
    output rdata_o, hazard_o
  );
endinterface

// File: rtl/rf_pending_cnt.sv
// Saturating pending-write counter with flush clear and sticky protocol error.
module rf_pending_cnt #(
  parameter int CNTW = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            err_o
);
  localparam logic [CNTW-1:0] PMAX = '1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // A flush squashes in-flight writes, so a same-cycle retire does not decrement.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNTW'(1) : '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == PMAX) err_d = 1'b1;
      else               cnt_d = cnt_q + CNTW'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write scoreboard, issue hazard and commit bypass.
module scoreboard_regfile
  import rf_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG   = DEF_NREG,
  parameter int NRD    = 2,
  parameter int CNTW   = DEF_CNTW,
  parameter int BYPASS = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  scoreboard_regfile_if.slave       bus,
  input  logic [$clog2(NREG)-1:0]   dbg_raddr_i,
  output logic [XLEN-1:0]           dbg_rdata_o,
  output logic                      err_o
);
  localparam int              AW      = $clog2(NREG);
  localparam logic [CNTW-1:0] PMAX    = '1;
  localparam logic [AW-1:0]   ADDR_X0 = AW'(X0);

  logic [CNTW-1:0] pend    [NREG];
  logic [XLEN-1:0] regs_q  [NREG];
  logic [XLEN-1:0] regs_d  [NREG];
  logic [XLEN-1:0] rd_data [NRD];
  logic [NREG-1:0] inc, dec, cnt_err;
  logic [NRD-1:0]  blocked;
  logic            commit_wr, issue_wr, wr_full;

  assign commit_wr = bus.commit_valid_i && bus.commit_wena_i && (bus.commit_waddr_i != ADDR_X0);
  assign issue_wr  = bus.issue_fire_i && bus.issue_wena_i && (bus.issue_waddr_i != ADDR_X0);

  assign pend[0]    = '0;
  assign inc[0]     = 1'b0;
  assign dec[0]     = 1'b0;
  assign cnt_err[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    assign inc[i] = issue_wr  && (bus.issue_waddr_i  == AW'(i));
    assign dec[i] = commit_wr && (bus.commit_waddr_i == AW'(i));

    rf_pending_cnt #(.CNTW(CNTW)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clr_i (bus.flush_i),
      .inc_i (inc[i]),
      .dec_i (dec[i]),
      .cnt_o (pend[i]),
      .err_o (cnt_err[i])
    );
  end

  always_comb begin
    regs_d = regs_q;
    if (commit_wr) regs_d[bus.commit_waddr_i] = bus.commit_wdata_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // Bypass only when the retiring write is the last one outstanding for that register.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr       = bus.raddr_i[k*AW +: AW];
    assign hit        = (BYPASS != 0) && commit_wr && (bus.commit_waddr_i == addr)
                        && (pend[addr] == CNTW'(1));
    assign blocked[k] = bus.rena_i[k] && (addr != ADDR_X0) && (pend[addr] != '0) && !hit;
    assign rd_data[k] = (!bus.rena_i[k] || addr == ADDR_X0) ? '0 :
                        hit ? bus.commit_wdata_i : regs_q[addr];
  end

  always_comb begin
    bus.rdata_o = '0;
    for (int k = 0; k < NRD; k++) bus.rdata_o[k*XLEN +: XLEN] = rd_data[k];
  end

  assign wr_full      = bus.issue_wena_i && (bus.issue_waddr_i != ADDR_X0)
                        && (pend[bus.issue_waddr_i] == PMAX);
  assign bus.hazard_o = bus.issue_valid_i && ((|blocked) || wr_full);

  assign dbg_rdata_o = (dbg_raddr_i == ADDR_X0) ? '0 : regs_q[dbg_raddr_i];
  assign err_o       = |cnt_err;
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed scenario bench for scoreboard_regfile with default parameters.
module tb_scoreboard_regfile;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [AW-1:0]   dbg_raddr;
  logic [XLEN-1:0] dbg_rdata;
  logic            err;
  int              total = 0;
  int              bad   = 0;

  scoreboard_regfile_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  scoreboard_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .CNTW(2), .BYPASS(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_raddr_i (dbg_raddr),
    .dbg_rdata_o (dbg_rdata),
    .err_o       (err)
  );

  always #5 clock = ~clock;

  task automatic idle();
    bus.issue_valid_i  = 0; bus.issue_fire_i = 0; bus.issue_wena_i = 0; bus.issue_waddr_i = '0;
    bus.rena_i         = '0; bus.raddr_i = '0;
    bus.commit_valid_i = 0; bus.commit_wena_i = 0; bus.commit_waddr_i = '0; bus.commit_wdata_i = '0;
    bus.flush_i        = 0;
    dbg_raddr          = '0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  task automatic fire(input logic [AW-1:0] rd);
    bus.issue_valid_i = 1; bus.issue_fire_i = 1; bus.issue_wena_i = 1; bus.issue_waddr_i = rd;
  endtask

  task automatic commit(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.commit_valid_i = 1; bus.commit_wena_i = 1; bus.commit_waddr_i = a; bus.commit_wdata_i = d;
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    bus.issue_valid_i = 1; bus.rena_i[0] = 1; bus.raddr_i[AW-1:0] = a;
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    bus.issue_valid_i = 1; bus.rena_i[1] = 1; bus.raddr_i[2*AW-1:AW] = a;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    idle();
    reset = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle();
    reset = 0;
    bus.rena_i = 2'b11; bus.raddr_i = {5'd10, 5'd5}; dbg_raddr = 5'd10;
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", bus.hazard_o); end
    total++; if (bus.rdata_o !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
    total++; if (dbg_rdata !== '0) begin bad++; $display("FAIL reset_dbg got=%h exp=0", dbg_rdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clock);
    reset = 1;
    idle();
    @(negedge clock);
  endtask

  task automatic test_bypass();
    apply_reset();
    fire(5'd5);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL byp_issue_hazard got=%b exp=0", bus.hazard_o); end
    step();
    rd0(5'd5);
    #1;
    total++; if (bus.hazard_o !== 1'b1) begin bad++; $display("FAIL byp_pending_hazard got=%b exp=1", bus.hazard_o); end
    step();
    rd0(5'd5);
    commit(5'd5, 32'hDEAD);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL byp_commit_hazard got=%b exp=0", bus.hazard_o); end
    total++; if (bus.rdata_o[31:0] !== 32'hDEAD) begin bad++; $display("FAIL byp_rdata got=%h exp=0000dead", bus.rdata_o[31:0]); end
    step();
    rd0(5'd5); dbg_raddr = 5'd5;
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL byp_after_hazard got=%b exp=0", bus.hazard_o); end
    total++; if (bus.rdata_o[31:0] !== 32'hDEAD) begin bad++; $display("FAIL byp_after_rdata got=%h exp=0000dead", bus.rdata_o[31:0]); end
    total++; if (dbg_rdata !== 32'hDEAD) begin bad++; $display("FAIL byp_dbg got=%h exp=0000dead", dbg_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fire(5'd7); step();
    fire(5'd7); step();
    rd0(5'd7); commit(5'd7, 32'h1111);
    #1;
    total++; if (bus.hazard_o !== 1'b1) begin bad++; $display("FAIL b2b_first_commit_hazard got=%b exp=1", bus.hazard_o); end
    step();
    rd1(5'd7); commit(5'd7, 32'h2222);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL b2b_last_commit_hazard got=%b exp=0", bus.hazard_o); end
    total++; if (bus.rdata_o[63:32] !== 32'h2222) begin bad++; $display("FAIL b2b_port1_bypass got=%h exp=00002222", bus.rdata_o[63:32]); end
    step();
    dbg_raddr = 5'd7;
    #1;
    total++; if (dbg_rdata !== 32'h2222) begin bad++; $display("FAIL b2b_dbg got=%h exp=00002222", dbg_rdata); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 3; i++) begin fire(5'd3); step(); end
    bus.issue_valid_i = 1; bus.issue_wena_i = 1; bus.issue_waddr_i = 5'd3;
    #1;
    total++; if (bus.hazard_o !== 1'b1) begin bad++; $display("FAIL sat_full_hazard got=%b exp=1", bus.hazard_o); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sat_err_before got=%b exp=0", err); end
    fire(5'd3);
    step();
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL sat_err_after got=%b exp=1", err); end
    commit(5'd3, 32'h3); step();
    commit(5'd3, 32'h3); step();
    rd0(5'd3);
    #1;
    total++; if (bus.hazard_o !== 1'b1) begin bad++; $display("FAIL sat_held_at_max got=%b exp=1", bus.hazard_o); end
    step();
    commit(5'd3, 32'h33); step();
    rd0(5'd3);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL sat_drained got=%b exp=0", bus.hazard_o); end
    total++; if (bus.rdata_o[31:0] !== 32'h33) begin bad++; $display("FAIL sat_rdata got=%h exp=00000033", bus.rdata_o[31:0]); end
    step();
  endtask

  task automatic test_underflow();
    apply_reset();
    commit(5'd9, 32'h99);
    step();
    dbg_raddr = 5'd9;
    rd0(5'd9);
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL uf_err got=%b exp=1", err); end
    total++; if (dbg_rdata !== 32'h99) begin bad++; $display("FAIL uf_dbg got=%h exp=00000099", dbg_rdata); end
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL uf_count_unchanged got=%b exp=0", bus.hazard_o); end
    step();
  endtask

  task automatic test_flush();
    apply_reset();
    fire(5'd4); step();
    fire(5'd6); step();
    fire(5'd6); bus.flush_i = 1; step();
    rd0(5'd4);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL flush_x4_hazard got=%b exp=0", bus.hazard_o); end
    step();
    rd1(5'd6);
    #1;
    total++; if (bus.hazard_o !== 1'b1) begin bad++; $display("FAIL flush_x6_hazard got=%b exp=1", bus.hazard_o); end
    commit(5'd6, 32'h66);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL flush_x6_count_one got=%b exp=0", bus.hazard_o); end
    total++; if (bus.rdata_o[63:32] !== 32'h66) begin bad++; $display("FAIL flush_x6_rdata got=%h exp=00000066", bus.rdata_o[63:32]); end
    step();
  endtask

  task automatic test_x0_and_midreset();
    apply_reset();
    commit(5'd0, 32'h1234); fire(5'd0); rd0(5'd0);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL x0_hazard got=%b exp=0", bus.hazard_o); end
    total++; if (bus.rdata_o[31:0] !== '0) begin bad++; $display("FAIL x0_bypass_rdata got=%h exp=0", bus.rdata_o[31:0]); end
    step();
    rd0(5'd0); bus.issue_wena_i = 1; bus.issue_waddr_i = 5'd0; dbg_raddr = 5'd0;
    #1;
    total++; if (bus.hazard_o !== 1'b0 || bus.rdata_o[31:0] !== '0) begin
      bad++; $display("FAIL x0_read got=%b/%h exp=0/0", bus.hazard_o, bus.rdata_o[31:0]);
    end
    total++; if (dbg_rdata !== '0) begin bad++; $display("FAIL x0_dbg got=%h exp=0", dbg_rdata); end
    step();
    fire(5'd10); step();
    fire(5'd10); step();
    fire(5'd11); commit(5'd10, 32'hAAAA); step();
    fire(5'd12); commit(5'd11, 32'hBBBB);
    #2;
    reset = 0;
    #1;
    bus.issue_valid_i = 0; dbg_raddr = 5'd10;
    #1;
    total++; if (dbg_rdata !== '0) begin bad++; $display("FAIL mid_reset_dbg got=%h exp=0", dbg_rdata); end
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL mid_reset_hazard got=%b exp=0", bus.hazard_o); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_reset_err got=%b exp=0", err); end
    @(negedge clock);
    idle();
    reset = 1;
    rd0(5'd10); rd1(5'd11);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL post_reset_hazard got=%b exp=0", bus.hazard_o); end
    step();
    bus.issue_valid_i = 1; bus.issue_wena_i = 1; bus.issue_waddr_i = 5'd12; rd0(5'd12);
    #1;
    total++; if (bus.hazard_o !== 1'b0) begin bad++; $display("FAIL post_reset_x12 got=%b exp=0", bus.hazard_o); end
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_back_to_back();
    test_saturate();
    test_underflow();
    test_flush();
    test_x0_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 SHALL have parameter NREG, default 32, meaning register count; AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning source read ports.
REQ-004 SHALL have parameter CNTW, default 2, meaning pending-write counter width; PMAX = 2^CNTW-1.
REQ-005 SHALL have parameter BYPASS, default 1, meaning commit-to-read forwarding enabled.
REQ-006 SHALL have port clock, input, 1, meaning the single clock; all state on posedge.
REQ-007 SHALL have port reset, input, 1, meaning reset, asynchronous and active-low.
REQ-008 SHALL have port issue_valid_i, input, 1, meaning decode presents an instruction.
REQ-009 SHALL have port issue_fire_i, input, 1, meaning decode handshake completed this cycle.
REQ-010 SHALL have port issue_wena_i, input, 1, meaning instruction writes rd.
REQ-011 SHALL have port issue_waddr_i, input, AW, meaning rd.
REQ-012 SHALL have ports rena_i, input, NRD, meaning per-port read enable; raddr_i, input, NRD*AW, meaning packed source addresses.
REQ-013 SHALL have port rdata_o, output, NRD*XLEN, meaning packed read data.
REQ-014 SHALL have port hazard_o, output, 1, meaning issue must stall.
REQ-015 SHALL have ports commit_valid_i, commit_wena_i (input, 1), commit_waddr_i (input, AW), commit_wdata_i (input, XLEN), meaning retirement write.
REQ-016 SHALL have port flush_i, input, 1, meaning squash all in-flight writes.
REQ-017 SHALL have ports dbg_raddr_i, input, AW, and dbg_rdata_o, output, XLEN, meaning debug/test read.
REQ-018 SHALL have port err_o, output, 1, meaning sticky protocol error.

Function
REQ-019 SHALL keep one CNTW-bit pending counter per register; register 0 is never pending and always reads 0.
REQ-020 SHALL increment pending[rd] on issue_fire_i && issue_wena_i && rd!=0.
REQ-021 SHALL decrement pending[a] on commit_valid_i && commit_wena_i && a!=0, and write regs[a] <= commit_wdata_i on the same edge.
REQ-022 SHALL leave the count unchanged when increment and decrement target the same register in one cycle.
REQ-023 SHALL treat source k as blocked when rena[k], raddr[k]!=0, pending!=0, and not bypass-hit.
REQ-024 SHALL define bypass-hit as BYPASS && commit write to raddr[k] this cycle && pending[raddr[k]]==1.
REQ-025 SHALL drive hazard_o = issue_valid_i && (any source blocked || (issue_wena_i && rd!=0 && pending[rd]==PMAX)); hazard_o is combinational, zero latency.
REQ-026 SHALL drive rdata[k] = 0 if !rena[k] or raddr[k]==0; else commit_wdata_i on bypass-hit; else regs[raddr[k]].
REQ-027 SHALL keep rdata independent of hazard_o.
REQ-028 SHALL clear all counters on flush_i; an issue_fire_i in the same cycle takes effect after the clear (count = 1); commit data is still written.
REQ-029 SHALL ignore a decrement at count 0 and set err_o.
REQ-030 SHALL hold the count at PMAX on an increment at PMAX and set err_o.
REQ-031 SHALL drive dbg_rdata_o = regs[dbg_raddr_i] combinationally, 0 for address 0.

Reset
REQ-032 SHALL, while reset is low, asynchronously clear all regs, all counters and err_o to 0.
REQ-033 SHALL drive hazard_o=0 in reset only if issue_valid_i=0; rdata_o then reads 0 for all addresses.
REQ-034 SHALL discard in-flight issue/commit on reset assertion mid-operation; the first edge after release behaves as from empty.

Structure
REQ-035 SHALL place XLEN/NREG/CNTW defaults and the x0 index in a shared package rf_pkg.
REQ-036 SHALL instantiate NREG-1 copies of sub-module rf_pending_cnt (saturating up/down counter with clear, sticky error flag).
REQ-037 SHALL implement the register array as flops with a single write port; read and bypass logic SHALL be generated per port.

Verification
REQ-038 Issue x5 write, then read x5 on port 0 -> hazard_o=1 until commit x5=0xDEAD; that cycle hazard_o=0, rdata0=0xDEAD (BYPASS=1).
REQ-039 Issue x7 twice, commit x7 once -> hazard_o stays 1; second commit -> hazard_o=0, regs[7]= last data.
REQ-040 Issue x3 three times (CNTW=2) -> fourth issue_valid with rd=x3 gives hazard_o=1; forced fire sets err_o, count stays 3.
REQ-041 Commit x9 with count 0 -> regs[9] written, err_o=1, counters unchanged.
REQ-042 Pending x4,x6 then flush_i with simultaneous fire rd=x6 -> pending x4=0, x6=1.
REQ-043 Write/read x0=0x1234 -> rdata=0, never hazard; assert reset mid-pending -> all counters 0, dbg_rdata_o=0 for x10.
